fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 36 +++
 rtl/fetch_next_pc.sv | 36 +++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching CPU: opcode constants, instruction field
// positions and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INSTR_W    = 8;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;
    localparam int IMM_HI = 1;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic [1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [1:0] instr_imm(input logic [INSTR_W-1:0] instr);
        return instr[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Sequential next-PC computation: pc + 1, plus the sign-extended 2-bit
// immediate when the fetched byte is a PC-relative jump.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PROG_LEN = 5
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  seq_pc,
    output logic               out_of_range
);

    localparam logic [ADDR_W-1:0] PROG_END = ADDR_W'(PROG_LEN);

    logic [1:0]               imm;
    logic signed [ADDR_W-1:0] offset;
    logic                     unused_fields;

    // rs/rt only matter to decode; fetch looks at opcode and imm alone
    assign unused_fields = &{1'b0, instruction[RS_HI:RT_LO]};

    assign imm = instr_imm(instruction);

    always_comb begin
        offset = '0;
        if (instr_opcode(instruction) == OP_JUMP) begin
            offset = {{(ADDR_W-2){imm[1]}}, imm};
        end
    end

    assign seq_pc       = pc + ADDR_W'(1) + $unsigned(offset);
    assign out_of_range = (seq_pc >= PROG_END);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory and
// registers the fetched byte into the IF/ID register for decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 5,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] Read_Address,
    input  logic [7:0]        instruction,
    output logic [7:0]        if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PROG_END = ADDR_W'(PROG_LEN);
    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] seq_pc;
    logic              seq_oor;
    logic              target_oor;

    fetch_next_pc #(
        .ADDR_W   (ADDR_W),
        .PROG_LEN (PROG_LEN)
    ) u_next_pc (
        .pc           (pc),
        .instruction  (instruction),
        .seq_pc       (seq_pc),
        .out_of_range (seq_oor)
    );

    // Memory never sees an address outside the program image
    assign Read_Address = (pc < PROG_END) ? pc : '0;
    assign target_oor   = (redirect_target >= PROG_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= PC_INIT;
            if_instr <= '0;
            if_pc    <= '0;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                HALT: begin
                    // Only an in-range redirect can restart fetch; en is ignored here
                    if (redirect_valid && !target_oor) begin
                        pc       <= redirect_target;
                        state    <= RUN;
                        halted   <= 1'b0;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    if (en) begin
                        state <= RUN;
                        if (redirect_valid) begin
                            pc       <= redirect_target;
                            if_valid <= 1'b0;
                            if (target_oor) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                        end else if (!stall) begin
                            if_instr <= instruction;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= seq_pc;
                            // The byte just captured is still valid even though fetch stops
                            if (seq_oor) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                        end
                    end else if (state == RUN && !stall) begin
                        if_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int ADDR_W   = 8;
    localparam int PROG_LEN = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              stall = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_target = '0;
    logic [ADDR_W-1:0] read_address;
    logic [7:0]        instruction;
    logic [7:0]        if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;
    logic              halted;

    logic [7:0] mem [0:255];
    logic [7:0] image [0:4];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: st 0 = idle, 1 = running, 2 = halted
    int         m_pc;
    int         m_st;
    int         m_ifpc;
    logic [7:0] m_instr;
    logic       m_valid;
    logic       m_halted;

    always #5 clk = ~clk;

    assign instruction = mem[read_address];

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .PROG_LEN (PROG_LEN),
        .RESET_PC (0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .Read_Address    (read_address),
        .instruction     (instruction),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .halted          (halted)
    );

    function automatic int next_pc(input int pc, input logic [7:0] ins);
        int off;
        int imm;
        off = 0;
        imm = int'(ins[1:0]);
        if (ins[7:6] == 2'b11) off = (imm >= 2) ? imm - 4 : imm;
        return (pc + 1 + off + 256) % 256;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_st = 0; m_ifpc = 0; m_instr = 8'h00; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_clock();
        int tgt;
        tgt = int'(redirect_target);
        if (m_st == 2) begin
            if (redirect_valid && tgt < PROG_LEN) begin
                m_pc = tgt; m_st = 1; m_halted = 1'b0; m_valid = 1'b0;
            end else if (!stall) begin
                m_valid = 1'b0;
            end
        end else if (en) begin
            m_st = 1;
            if (redirect_valid) begin
                m_pc = tgt; m_valid = 1'b0;
                if (m_pc >= PROG_LEN) begin m_st = 2; m_halted = 1'b1; end
            end else if (!stall) begin
                m_instr = mem[m_pc]; m_ifpc = m_pc; m_valid = 1'b1;
                m_pc = next_pc(m_pc, m_instr);
                if (m_pc >= PROG_LEN) begin m_st = 2; m_halted = 1'b1; end
            end
        end else if (m_st == 1 && !stall) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        if (rst_n) model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 5; i++) mem[i] = image[i];
    endtask

    task automatic apply_reset();
        en = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_tests++;
        if ({if_instr, if_pc, if_valid, halted, read_address} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_values: got instr=%h pc=%h v=%b h=%b ra=%h, want all zero",
                     if_instr, if_pc, if_valid, halted, read_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        n_tests++;
        if (if_valid !== 1'b0 || halted !== 1'b0 || read_address !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got v=%b h=%b ra=%h, want v=0 h=0 ra=00", if_valid, halted, read_address);
        end
    endtask

    task automatic test_program_run();
        logic [7:0] exp_pc [0:3];
        logic [7:0] exp_in [0:3];
        exp_pc[0] = 8'd0;  exp_pc[1] = 8'd1;  exp_pc[2] = 8'd3;  exp_pc[3] = 8'd4;
        exp_in[0] = 8'h49; exp_in[1] = 8'hC1; exp_in[2] = 8'hA9; exp_in[3] = 8'h4D;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (if_pc !== exp_pc[i] || if_instr !== exp_in[i] || if_valid !== 1'b1 || halted !== (i == 3)) begin
                n_fail++;
                $display("FAIL run_step%0d: got pc=%h instr=%h v=%b h=%b, want pc=%h instr=%h v=1 h=%b",
                         i, if_pc, if_instr, if_valid, halted, exp_pc[i], exp_in[i], (i == 3));
            end
        end
        n_tests++;
        if (read_address !== 8'd0) begin
            n_fail++;
            $display("FAIL halt_addr: got ra=%h, want 00", read_address);
        end
        tick();
        n_tests++;
        if (if_valid !== 1'b0 || halted !== 1'b1 || read_address !== 8'd0) begin
            n_fail++;
            $display("FAIL halt_idle: got v=%b h=%b ra=%h, want v=0 h=1 ra=00", if_valid, halted, read_address);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        en = 1'b1;
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (if_instr !== 8'hC1 || if_pc !== 8'd1 || if_valid !== 1'b1 || read_address !== 8'd3) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got instr=%h pc=%h v=%b ra=%h, want instr=c1 pc=01 v=1 ra=03",
                         i, if_instr, if_pc, if_valid, read_address);
            end
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (if_instr !== 8'hA9 || if_pc !== 8'd3 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume: got instr=%h pc=%h v=%b, want instr=a9 pc=03 v=1", if_instr, if_pc, if_valid);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        en = 1'b1;
        tick(); tick();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'd2;
        tick();
        n_tests++;
        if (if_valid !== 1'b0 || read_address !== 8'd2 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_squash: got v=%b ra=%h h=%b, want v=0 ra=02 h=0", if_valid, read_address, halted);
        end
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        n_tests++;
        if (if_instr !== 8'h18 || if_pc !== 8'd2 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_fetch: got instr=%h pc=%h v=%b, want instr=18 pc=02 v=1", if_instr, if_pc, if_valid);
        end
        tick();
        n_tests++;
        if (if_instr !== 8'hA9 || if_pc !== 8'd3) begin
            n_fail++;
            $display("FAIL redirect_follow: got instr=%h pc=%h, want instr=a9 pc=03", if_instr, if_pc);
        end
    endtask

    task automatic test_halt_redirect();
        apply_reset();
        en = 1'b1;
        repeat (5) tick();
        en = 1'b0; redirect_valid = 1'b1; redirect_target = 8'd7;
        tick();
        n_tests++;
        if (halted !== 1'b1 || read_address !== 8'd0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_oor_redirect: got h=%b ra=%h v=%b, want h=1 ra=00 v=0", halted, read_address, if_valid);
        end
        redirect_target = 8'd0;
        tick();
        n_tests++;
        if (halted !== 1'b0 || if_valid !== 1'b0 || read_address !== 8'd0) begin
            n_fail++;
            $display("FAIL halt_exit: got h=%b v=%b ra=%h, want h=0 v=0 ra=00", halted, if_valid, read_address);
        end
        redirect_valid = 1'b0; en = 1'b1;
        tick();
        n_tests++;
        if (if_instr !== 8'h49 || if_pc !== 8'd0 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_restart: got instr=%h pc=%h v=%b, want instr=49 pc=00 v=1", if_instr, if_pc, if_valid);
        end
    endtask

    task automatic test_jump_wrap();
        mem[0] = 8'hC2;
        apply_reset();
        en = 1'b1;
        tick();
        n_tests++;
        if (if_instr !== 8'hC2 || if_pc !== 8'd0 || if_valid !== 1'b1 || halted !== 1'b1 || read_address !== 8'd0) begin
            n_fail++;
            $display("FAIL jump_wrap: got instr=%h pc=%h v=%b h=%b ra=%h, want instr=c2 pc=00 v=1 h=1 ra=00",
                     if_instr, if_pc, if_valid, halted, read_address);
        end
        mem[0] = image[0];
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({if_instr, if_pc, if_valid, halted, read_address} !== 26'd0) begin
            n_fail++;
            $display("FAIL async_reset: got instr=%h pc=%h v=%b h=%b ra=%h, want all zero",
                     if_instr, if_pc, if_valid, halted, read_address);
        end
        #3;
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        n_tests++;
        if (if_valid !== 1'b0 || read_address !== 8'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_idle: got v=%b ra=%h h=%b, want v=0 ra=00 h=0", if_valid, read_address, halted);
        end
        en = 1'b1;
        tick();
        n_tests++;
        if (if_instr !== 8'h49 || if_pc !== 8'd0 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_restart: got instr=%h pc=%h v=%b, want instr=49 pc=00 v=1", if_instr, if_pc, if_valid);
        end
    endtask

    task automatic test_random();
        logic [25:0] got;
        logic [25:0] exp;
        logic [7:0]  exp_ra;
        for (int i = 0; i < 5; i++) mem[i] = 8'($urandom);
        mem[$urandom_range(0, 4)] = {2'b11, 4'($urandom), 2'($urandom)};
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            en              = ($urandom_range(0, 3) != 0);
            stall           = ($urandom_range(0, 3) == 0);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = 8'($urandom_range(0, 7));
            tick();
            exp_ra = (m_pc < PROG_LEN) ? 8'(m_pc) : 8'd0;
            exp = {m_instr, 8'(m_ifpc), m_valid, m_halted, exp_ra};
            got = {if_instr, if_pc, if_valid, halted, read_address};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got {instr,pc,v,h,ra}=%h, want %h", cyc, got, exp);
            end
        end
        load_image();
    endtask

    initial begin
        image[0] = 8'h49; image[1] = 8'hC1; image[2] = 8'h18; image[3] = 8'hA9; image[4] = 8'h4D;
        load_image();
        test_reset();
        test_program_run();
        test_stall();
        test_redirect();
        test_halt_redirect();
        test_jump_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
